axil_apb_req_ctrl: RTL

//  AXI4-Lite slave front end of the AXI4-Lite-to-APB bridge; sits directly upstream of apb_master.

---
 rtl/axil_apb_req_ctrl_if.sv | 49 ++++
 rtl/axil_apb_req_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_apb_req_ctrl_if.sv
// Signal bundle between the AXI4-Lite master, the request controller and
// the apb_master transfer port.
//   AW/W/B/AR/R : AXI4-Lite slave channels
//   STREQ/SWRT/SSEL/SADDR/SWDATA : transfer request towards apb_master
//   SRDATA/M_STATE/PREADY/PSLVERR : read data, master state, APB completion
// modport slave  : used by axil_apb_req_ctrl
// modport master : used by whatever drives the AXI side and models apb_master
interface axil_apb_req_ctrl_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        STREQ;
    logic        SWRT;
    logic        SSEL;
    logic [31:0] SADDR;
    logic [31:0] SWDATA;
    logic [31:0] SRDATA;
    logic [1:0]  M_STATE;
    logic        PREADY;
    logic        PSLVERR;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARADDR, ARVALID, RREADY, SRDATA, M_STATE, PREADY, PSLVERR,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output STREQ, SWRT, SSEL, SADDR, SWDATA
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARADDR, ARVALID, RREADY, SRDATA, M_STATE, PREADY, PSLVERR,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  STREQ, SWRT, SSEL, SADDR, SWDATA
    );
endinterface

// File: rtl/axil_apb_req_ctrl.sv
// AXI4-Lite slave front end of the AXI4-Lite-to-APB bridge.
// Captures AW/W/AR, arbitrates write vs read (strict alternation on
// collision), decodes the address window and hands one transfer at a time
// to apb_master, then returns the B or R response. Single outstanding.
// Ports:
//   PCLK   : bridge clock, shared with apb_master
//   PRESET : synchronous active-high reset, shared with apb_master
//   bus    : AXI4-Lite channels plus apb_master request/status (slave modport)
//
// state  | meaning
// IDLE   | accepting AW/W/AR, arbitrating held requests
// REQ    | STREQ high, waiting for apb_master to enter Setup
// WAIT   | APB access in flight, waiting for PREADY in Access
// RESP   | B or R response valid, waiting for the handshake
module axil_apb_req_ctrl #(
    parameter logic [31:0] C_BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] C_ADDR_MASK   = 32'hFFFF_F000,
    parameter bit          C_STRICT_STRB = 1'b1
) (
    input  logic                PCLK,
    input  logic                PRESET,
    axil_apb_req_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] M_SETUP     = 2'd1;
    localparam logic [1:0] M_ACCESS    = 2'd2;

    state_t      state_q, state_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wr_prio_q, wr_prio_d;
    logic        streq_q, streq_d, swrt_q, swrt_d, ssel_q, ssel_d;
    logic [31:0] saddr_q, saddr_d, swdata_q, swdata_d, rdata_q, rdata_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  resp_q, resp_d;

    logic        aw_rdy, w_rdy, ar_rdy;
    logic        wr_pend, start_wr, start_rd;
    logic [31:0] req_addr;

    // Readies are held low during reset so every output reads 0 there.
    assign aw_rdy = !aw_held_q && (state_q == S_IDLE) && !PRESET;
    assign w_rdy  = !w_held_q  && (state_q == S_IDLE) && !PRESET;
    assign ar_rdy = !ar_held_q && (state_q == S_IDLE) && !PRESET;

    assign bus.AWREADY = aw_rdy;
    assign bus.WREADY  = w_rdy;
    assign bus.ARREADY = ar_rdy;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = resp_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = resp_q;
    assign bus.RDATA   = rdata_q;
    assign bus.STREQ   = streq_q;
    assign bus.SWRT    = swrt_q;
    assign bus.SSEL    = ssel_q;
    assign bus.SADDR   = saddr_q;
    assign bus.SWDATA  = swdata_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            ar_held_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            wr_prio_q <= 1'b1;
            streq_q   <= 1'b0;
            swrt_q    <= 1'b0;
            ssel_q    <= 1'b0;
            saddr_q   <= '0;
            swdata_q  <= '0;
            rdata_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            ar_held_q <= ar_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            wr_prio_q <= wr_prio_d;
            streq_q   <= streq_d;
            swrt_q    <= swrt_d;
            ssel_q    <= ssel_d;
            saddr_q   <= saddr_d;
            swdata_q  <= swdata_d;
            rdata_q   <= rdata_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        ar_held_d = ar_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        wr_prio_d = wr_prio_q;
        streq_d   = streq_q;
        swrt_d    = swrt_q;
        ssel_d    = ssel_q;
        saddr_d   = saddr_q;
        swdata_d  = swdata_q;
        rdata_d   = rdata_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        resp_d    = resp_q;

        // Arbitration works on already-held requests, so the decision is
        // registered one cycle after the channel handshake.
        wr_pend  = aw_held_q && w_held_q;
        start_wr = wr_pend && (!ar_held_q || wr_prio_q);
        start_rd = ar_held_q && (!wr_pend || !wr_prio_q);
        req_addr = start_wr ? awaddr_q : araddr_q;

        if (bus.AWVALID && aw_rdy) begin
            aw_held_d = 1'b1;
            awaddr_d  = bus.AWADDR;
        end
        if (bus.WVALID && w_rdy) begin
            w_held_d = 1'b1;
            wdata_d  = bus.WDATA;
            wstrb_d  = bus.WSTRB;
        end
        if (bus.ARVALID && ar_rdy) begin
            ar_held_d = 1'b1;
            araddr_d  = bus.ARADDR;
        end

        case (state_q)
            S_IDLE: begin
                if (start_wr || start_rd) begin
                    if (wr_pend && ar_held_q) wr_prio_d = !wr_prio_q;
                    saddr_d = req_addr;
                    swrt_d  = start_wr;
                    if (start_wr) swdata_d = wdata_q;
                    if ((req_addr & C_ADDR_MASK) != (C_BASE_ADDR & C_ADDR_MASK)) begin
                        resp_d   = RESP_DECERR;
                        if (start_rd) rdata_d = '0;
                        bvalid_d = start_wr;
                        rvalid_d = start_rd;
                        state_d  = S_RESP;
                    end else if (C_STRICT_STRB && start_wr && (wstrb_q != 4'hF)) begin
                        resp_d   = RESP_SLVERR;
                        bvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        ssel_d  = 1'b1;
                        streq_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Dropping STREQ once Setup is seen keeps apb_master from
                // chaining a second transfer after this one completes.
                if (bus.M_STATE == M_SETUP) begin
                    streq_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((bus.M_STATE == M_ACCESS) && bus.PREADY) begin
                    resp_d   = bus.PSLVERR ? RESP_SLVERR : RESP_OKAY;
                    if (!swrt_q) rdata_d = bus.SRDATA;
                    ssel_d   = 1'b0;
                    bvalid_d = swrt_q;
                    rvalid_d = !swrt_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if ((bvalid_q && bus.BREADY) || (rvalid_q && bus.RREADY)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    if (swrt_q) begin
                        aw_held_d = 1'b0;
                        w_held_d  = 1'b0;
                    end else begin
                        ar_held_d = 1'b0;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
